eda_pixel_loader: RTL
=====================

// Module: eda_pixel_loader
// PURPOSE
//  Upstream feeder for eda_regional_max. Accepts a raster-order pixel stream over a valid/ready handshake.
//  Converts it into the core's image-RAM write port (wr_addr={i,j}, pixel_in, write_en).
//  After the last pixel of an M x N frame it pulses start, then stalls the stream until the core reports done.
// PARAMETERS
//  M            16  image rows
//  N            16  image columns
//  PIXEL_WIDTH  8   pixel bits
//  I_WIDTH      4   row index bits, M <= 2**I_WIDTH
//  J_WIDTH      4   column index bits, N <= 2**J_WIDTH
//  ADDR_WIDTH   8   = I_WIDTH + J_WIDTH
// PORTS
//  clk         in   1            clock; all logic on posedge
//  reset_n     in   1            synchronous reset, active-low
//  s_valid     in   1            stream pixel valid
//  s_pixel     in   PIXEL_WIDTH  stream pixel, raster order (row 0 col 0 first)
//  s_ready     out  1            loader can accept a pixel
//  wr_addr     out  ADDR_WIDTH   to core: {i[I_WIDTH-1:0], j[J_WIDTH-1:0]}
//  pixel_in    out  PIXEL_WIDTH  to core: write data
//  write_en    out  1            to core: one-cycle write strobe per pixel
//  start       out  1            to core: one-cycle frame start pulse
//  done        in   1            from core: regional-max result ready
//  busy        out  1            frame handed to core, waiting for done
//  frame_done  out  1            one-cycle pulse, frame completed
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): state=LOAD, i=j=0. wr_addr, pixel_in, write_en, start, busy and frame_done are all 0.
//    s_ready is combinational = (state==LOAD), so it is 1 from the first cycle after reset.
//  - Reset mid-frame discards the partial frame; the next accepted pixel is written to address 0.
//  - Transfer = s_valid && s_ready at posedge.
//  - On a transfer, the next cycle shows write_en=1, wr_addr={i,j}, pixel_in=s_pixel (registered, latency 1).
//  - With no transfer, write_en=0 and wr_addr/pixel_in hold their last values.
//  - Counters: j++ per transfer. At j==N-1, j wraps to 0 and i++. On the transfer of (M-1,N-1), i and j clear to 0.
//  - FSM:
//      LOAD  -> START on transfer of (M-1,N-1).
//      START -> WAIT unconditionally. start=1 for exactly this one cycle, which is the same cycle write_en shows pixel (M-1,N-1).
//      WAIT  -> LOAD when done=1. busy=1 in START and WAIT.
//  - Core registers writes on the same edge it samples start, so the last pixel is stored before the search begins.
//  - frame_done=1 for one cycle after done is sampled in WAIT. s_ready returns to 1 in that same cycle.
//  - done sampled in LOAD or START is ignored: no state change, no frame_done.
//  - s_valid while s_ready=0: no transfer. The source holds s_pixel per the handshake.
//  - Back-to-back: a new frame may begin on the cycle frame_done is high. Its first write targets address 0.
//  - Throughput: one pixel per cycle in LOAD; M*N+1 cycles minimum from first transfer to start.
// CONFIGURATION
//  EDA_LOADER_LAST_CHECK_EN defined:
//   - Adds input s_last (1 bit, qualified by transfer) and output frame_err (1 bit, reset 0).
//   - s_last on a pixel other than (M-1,N-1): that pixel is still written; i,j clear to 0; no start.
//     frame_err=1 sticky until the next transfer with i=j=0.
//   - s_last=0 on pixel (M-1,N-1): frame_err=1; start is still issued normally.
//  EDA_LOADER_LAST_CHECK_EN undefined:
//   - s_last and frame_err ports are absent; frame boundary is by count only.
// TESTING (bench: M=N=4, I_WIDTH=J_WIDTH=2, ADDR_WIDTH=4)
//  1. 16 pixels 0x10..0x1F, s_valid held 1 -> write_en high 16 consecutive cycles, wr_addr 0x0..0xF,
//     pixel_in 0x10..0x1F; start=1 with the 0xF write; s_ready=0 from the next cycle on.
//  2. Same frame, s_valid toggling 1/0 -> 16 single-cycle write_en strobes at the same addresses; start once, with write 0xF.
//  3. done pulsed 5 cycles after start -> frame_done=1 next cycle, busy=0, s_ready=1;
//     second frame's first pixel written to 0x0.
//  4. reset_n=0 for 1 cycle after 7 transfers -> all outputs 0; the next pixel 0xAA is written to 0x0; no start before 16 further pixels.
//  5. done=1 while in LOAD after 3 pixels -> no frame_done, counters unchanged, the 4th pixel goes to 0x3.
//  6. [EDA_LOADER_LAST_CHECK_EN] s_last on the 10th pixel -> write to 0x9, frame_err=1, no start;
//     the next pixel goes to 0x0 and clears frame_err.

Source files
------------

// File: rtl/eda_pixel_loader.sv
// ---------------------------------------------------------------------------
// eda_pixel_loader
//   Upstream feeder for eda_regional_max. Takes a raster-order pixel stream
//   over a valid/ready handshake and turns it into the core's image-RAM write
//   port. After the last pixel of an M x N frame it pulses start, then holds
//   off the stream until the core reports done.
//
// Ports
//   clk         clock, all logic on posedge
//   reset_n     synchronous reset, active-low
//   s_valid     stream pixel valid
//   s_pixel     stream pixel, raster order (row 0 col 0 first)
//   s_ready     loader can accept a pixel (combinational: state == LOAD)
//   wr_addr     to core: {i, j} of the pixel being written
//   pixel_in    to core: write data
//   write_en    to core: one-cycle write strobe per pixel
//   start       to core: one-cycle frame start pulse
//   done        from core: regional-max result ready
//   busy        frame handed to core, waiting for done
//   frame_done  one-cycle pulse, frame completed
//
// Optional build macro EDA_LOADER_LAST_CHECK_EN adds:
//   s_last      in: end-of-frame marker, qualified by a transfer
//   frame_err   out: sticky framing error, cleared by the next transfer
//               that lands on address 0
// ---------------------------------------------------------------------------
module eda_pixel_loader #(
  parameter int M           = 16,
  parameter int N           = 16,
  parameter int PIXEL_WIDTH = 8,
  parameter int I_WIDTH     = 4,
  parameter int J_WIDTH     = 4,
  parameter int ADDR_WIDTH  = I_WIDTH + J_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   s_valid,
  input  logic [PIXEL_WIDTH-1:0] s_pixel,
  output logic                   s_ready,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [PIXEL_WIDTH-1:0] pixel_in,
  output logic                   write_en,
  output logic                   start,
  input  logic                   done,
  output logic                   busy,
  output logic                   frame_done
`ifdef EDA_LOADER_LAST_CHECK_EN
  ,
  input  logic                   s_last,
  output logic                   frame_err
`endif
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                 state_reg;
  logic [I_WIDTH-1:0]     i_reg;
  logic [J_WIDTH-1:0]     j_reg;
  logic [ADDR_WIDTH-1:0]  wr_addr_reg;
  logic [PIXEL_WIDTH-1:0] pixel_reg;
  logic                   write_en_reg;
  logic                   start_reg;
  logic                   busy_reg;
  logic                   frame_done_reg;

  logic xfer;
  logic last_col;
  logic last_pix;
  logic clear_cnt;

  assign s_ready  = (state_reg == ST_LOAD);
  assign xfer     = s_valid && s_ready;
  assign last_col = (j_reg == J_WIDTH'(N - 1));
  assign last_pix = last_col && (i_reg == I_WIDTH'(M - 1));

`ifdef EDA_LOADER_LAST_CHECK_EN
  logic frame_err_reg;
  logic early_last;

  // An early s_last truncates the frame: counters restart but no start.
  assign early_last = s_last && !last_pix;
  assign clear_cnt  = last_pix || early_last;
  assign frame_err  = frame_err_reg;
`else
  assign clear_cnt  = last_pix;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= ST_LOAD;
      i_reg          <= '0;
      j_reg          <= '0;
      wr_addr_reg    <= '0;
      pixel_reg      <= '0;
      write_en_reg   <= 1'b0;
      start_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      write_en_reg   <= xfer;
      start_reg      <= 1'b0;
      frame_done_reg <= 1'b0;

      // Address/data hold their last values when no pixel moves.
      if (xfer) begin
        wr_addr_reg <= {i_reg, j_reg};
        pixel_reg   <= s_pixel;
        if (clear_cnt) begin
          i_reg <= '0;
          j_reg <= '0;
        end else if (last_col) begin
          i_reg <= i_reg + 1'b1;
          j_reg <= '0;
        end else begin
          j_reg <= j_reg + 1'b1;
        end
      end

      // start is raised on the same edge that registers the last write, so
      // the core sees the final pixel and start together.
      case (state_reg)
        ST_LOAD: begin
          if (xfer && last_pix) begin
            state_reg <= ST_START;
            start_reg <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        ST_START: begin
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done) begin
            state_reg      <= ST_LOAD;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_LOAD;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

`ifdef EDA_LOADER_LAST_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_err_reg <= 1'b0;
    end else if (xfer) begin
      // Setting takes priority over clearing on a first-pixel transfer.
      if (early_last || (last_pix && !s_last)) begin
        frame_err_reg <= 1'b1;
      end else if ((i_reg == '0) && (j_reg == '0)) begin
        frame_err_reg <= 1'b0;
      end
    end
  end
`endif

  assign wr_addr    = wr_addr_reg;
  assign pixel_in   = pixel_reg;
  assign write_en   = write_en_reg;
  assign start      = start_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;

endmodule
